// File: rtl/trng_pkg.sv
// Shared types and constants for the NLFSR sequencing controller and its byte packer.
package trng_pkg;

  localparam int unsigned ByteW               = 8;
  localparam int unsigned WarmupCyclesDefault = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWarmup,
    StRun
  } seq_state_e;

endpackage

// File: rtl/nlfsr_seq_ctrl_if.sv
// Random-byte output stream: producer presents out_data/out_valid, consumer answers out_ready.
interface nlfsr_seq_ctrl_if;
  import trng_pkg::*;

  logic [ByteW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/trng_byte_pack.sv
// Packs sampled bits LSB first into bytes, holds one byte for the consumer and counts drops.
module trng_byte_pack
  import trng_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             flush_i,
  input  logic             clr_ovf_i,
  output logic [ByteW-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       ovf_cnt_o
);

  localparam int unsigned CntW = $clog2(ByteW);

  logic [ByteW-2:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ByteW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             done;

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    done    = 1'b0;

    if (flush_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (bit_valid_i) begin
      // Newest bit enters at the top so the first bit ends up in bit 0.
      sh_d  = {bit_i, sh_q[ByteW-2:1]};
      cnt_d = cnt_q + CntW'(1);
      done  = (cnt_q == CntW'(ByteW - 1));
    end

    if (done) begin
      if (!valid_q || out_ready_i) begin
        data_d  = {bit_i, sh_q};
        valid_d = 1'b1;
      end else if (ovf_q != 8'hff) begin
        ovf_d = ovf_q + 8'd1;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end

    if (clr_ovf_i) begin
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign ovf_cnt_o   = ovf_q;

endmodule

// File: rtl/nlfsr_seq_ctrl.sv
// Sequences an external NLFSR through serial seed load, warm-up mixing and run, packing a0 into
// bytes.
module nlfsr_seq_ctrl
  import trng_pkg::*;
#(
  parameter int unsigned SEED_W        = 17,
  parameter int unsigned WARMUP_CYCLES = WarmupCyclesDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              det_mode,
  input  logic [SEED_W-1:0] seed,
  output logic              nlfsr_load,
  output logic              nlfsr_d1,
  output logic              nlfsr_init,
  output logic              nlfsr_ce,
  input  logic              nlfsr_a0,
  nlfsr_seq_ctrl_if.master  out_if,
  output logic              busy,
  output logic [7:0]        ovf_cnt
);

  localparam int unsigned CntMax = (SEED_W > WARMUP_CYCLES) ? SEED_W : WARMUP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              flush;
  logic              clr_ovf;
  logic              bit_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    flush   = 1'b0;
    clr_ovf = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          seed_d  = seed;
          flush   = 1'b1;
          clr_ovf = 1'b1;
        end
      end
      StLoad: begin
        // Seed shifts out LSB first; bit 0 of seed_q is always the current serial bit.
        seed_d = seed_q >> 1;
        if (cnt_q == CntW'(SEED_W - 1)) begin
          state_d = StWarmup;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWarmup: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(WARMUP_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          flush   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
    end
  end

  assign nlfsr_load = (state_q == StLoad);
  assign nlfsr_d1   = (state_q == StLoad) & seed_q[0];
  assign nlfsr_init = (state_q == StWarmup) | ((state_q == StRun) & ~det_mode);
  assign nlfsr_ce   = (state_q == StWarmup) | ((state_q == StRun) & ~det_mode);
  assign busy       = (state_q != StIdle);
  assign bit_valid  = (state_q == StRun) & ~stop;

  trng_byte_pack u_byte_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid_i (bit_valid),
    .bit_i       (nlfsr_a0),
    .flush_i     (flush),
    .clr_ovf_i   (clr_ovf),
    .out_data_o  (out_if.out_data),
    .out_valid_o (out_if.out_valid),
    .out_ready_i (out_if.out_ready),
    .ovf_cnt_o   (ovf_cnt)
  );

endmodule
